// File: rtl/noc_inject_buffer.sv
// ---------------------------------------------------------------------------
// noc_inject_buffer
//
// Local-port injection stage between a NoC endpoint and its router's local
// input. Every virtual channel has its own flit FIFO. A wormhole arbiter
// locks onto one VC at a header and forwards that packet, header through
// tail, onto the shared link. A body/tail flit that reaches arbitration
// without a preceding header is an orphan: it is dropped and flagged.
//
// Flit format: bit FLIT_W-1 = is_header, bit FLIT_W-2 = is_tail,
// lower bits = payload.
//
// Parameters:
//   NUM_VC  number of virtual channels (codebase Noc_VC_Channel, 4)
//   DEPTH   flit FIFO depth per VC, power of two, >= 2
//   FLIT_W  flit width (codebase Noc_Data_Width + 2, 34)
//
// Ports:
//   noc_clk       clock
//   noc_rst_n     asynchronous active-low reset, flushes FIFOs and the lock
//   in_valid      per-VC flit valid from the endpoint
//   in_flit       per-VC flit from the endpoint
//   in_ready      per-VC space available (FIFO not full)
//   out_valid     one-hot flit valid toward the router, zero when idle
//   out_flit      flit of the locked VC, zero when out_valid is zero
//   out_ready     per-VC router-side ready
//   err_orphan    one-cycle pulse when an orphan flit is dropped
//   err_vc        VC of the most recent orphan drop
//   stat_pkts     (NOC_INJ_STATS_EN only) saturating count of tail transfers
//   stat_orphans  (NOC_INJ_STATS_EN only) saturating count of orphan drops
//
// Optional feature macro: NOC_INJ_STATS_EN
// ---------------------------------------------------------------------------
module noc_inject_buffer #(
    parameter int NUM_VC = 4,
    parameter int DEPTH  = 4,
    parameter int FLIT_W = 34
) (
    input  logic                           noc_clk,
    input  logic                           noc_rst_n,
    input  logic [NUM_VC-1:0]              in_valid,
    input  logic [NUM_VC-1:0][FLIT_W-1:0]  in_flit,
    output logic [NUM_VC-1:0]              in_ready,
    output logic [NUM_VC-1:0]              out_valid,
    output logic [FLIT_W-1:0]              out_flit,
    input  logic [NUM_VC-1:0]              out_ready,
    output logic                           err_orphan,
`ifdef NOC_INJ_STATS_EN
    output logic [31:0]                    stat_pkts,
    output logic [15:0]                    stat_orphans,
`endif
    output logic [$clog2(NUM_VC)-1:0]      err_vc
);

    localparam int VW = $clog2(NUM_VC);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_INC   = {{AW{1'b0}}, 1'b1};
    localparam logic [PW-1:0] PTR_DEPTH = PW'(DEPTH);
    localparam logic [VW-1:0] VC_INC    = {{(VW-1){1'b0}}, 1'b1};
    localparam logic [VW-1:0] VC_LAST   = VW'(NUM_VC - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    // FIFO storage and pointers; pointers carry one extra wrap bit
    logic [FLIT_W-1:0] mem_r    [NUM_VC][DEPTH];
    logic [PW-1:0]     wr_ptr_r [NUM_VC];
    logic [PW-1:0]     rd_ptr_r [NUM_VC];
    logic [FLIT_W-1:0] head_s   [NUM_VC];
    logic [NUM_VC-1:0] empty_s;
    logic [NUM_VC-1:0] full_s;
    logic [NUM_VC-1:0] push_s;
    logic [NUM_VC-1:0] pop_s;

    // Arbiter / FSM state
    state_t            state_r;
    state_t            state_nxt_s;
    logic [VW-1:0]     lock_vc_r;
    logic [VW-1:0]     lock_vc_nxt_s;
    logic [VW-1:0]     rr_ptr_r;
    logic [VW-1:0]     rr_ptr_nxt_s;
    logic              found_s;
    logic [VW-1:0]     win_s;
    logic [VW-1:0]     win_inc_s;
    logic              orphan_s;
    logic              err_orphan_r;
    logic [VW-1:0]     err_vc_r;

    // FIFO status, head flits and accepted pushes
    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            empty_s[v] = (wr_ptr_r[v] == rd_ptr_r[v]);
            full_s[v]  = ((wr_ptr_r[v] - rd_ptr_r[v]) == PTR_DEPTH);
            head_s[v]  = mem_r[v][rd_ptr_r[v][AW-1:0]];
            push_s[v]  = in_valid[v] & ~full_s[v];
        end
    end

    // A full FIFO refuses pushes even when it pops in the same cycle
    assign in_ready = ~full_s;

    // FIFO pointers; reset flushes every VC immediately
    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            for (int v = 0; v < NUM_VC; v++) begin
                wr_ptr_r[v] <= {PW{1'b0}};
                rd_ptr_r[v] <= {PW{1'b0}};
            end
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (push_s[v]) begin
                    wr_ptr_r[v] <= wr_ptr_r[v] + PTR_INC;
                end
                if (pop_s[v]) begin
                    rd_ptr_r[v] <= rd_ptr_r[v] + PTR_INC;
                end
            end
        end
    end

    // FIFO storage write; contents need no reset since pointers gate them
    always_ff @(posedge noc_clk) begin
        for (int v = 0; v < NUM_VC; v++) begin
            if (push_s[v]) begin
                mem_r[v][wr_ptr_r[v][AW-1:0]] <= in_flit[v];
            end
        end
    end

    // Round-robin scan starting at rr_ptr for the first non-empty VC
    always_comb begin
        int idx_v;
        idx_v   = 0;
        found_s = 1'b0;
        win_s   = {VW{1'b0}};
        for (int i = 0; i < NUM_VC; i++) begin
            idx_v = int'(rr_ptr_r) + i;
            if (idx_v >= NUM_VC) begin
                idx_v = idx_v - NUM_VC;
            end else begin
                idx_v = idx_v;
            end
            if (!found_s && !empty_s[idx_v]) begin
                found_s = 1'b1;
                win_s   = VW'(idx_v);
            end else begin
                found_s = found_s;
            end
        end
        if (win_s == VC_LAST) begin
            win_inc_s = {VW{1'b0}};
        end else begin
            win_inc_s = win_s + VC_INC;
        end
    end

    // Next-state: lock on a header, drop orphans in IDLE, release on tail pop
    always_comb begin
        state_nxt_s   = state_r;
        lock_vc_nxt_s = lock_vc_r;
        rr_ptr_nxt_s  = rr_ptr_r;
        pop_s         = {NUM_VC{1'b0}};
        orphan_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (found_s) begin
                    rr_ptr_nxt_s = win_inc_s;
                    if (head_s[win_s][FLIT_W-1]) begin
                        state_nxt_s   = ST_LOCK;
                        lock_vc_nxt_s = win_s;
                    end else begin
                        pop_s[win_s] = 1'b1;
                        orphan_s     = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOCK: begin
                if (!empty_s[lock_vc_r] && out_ready[lock_vc_r]) begin
                    pop_s[lock_vc_r] = 1'b1;
                    if (head_s[lock_vc_r][FLIT_W-2]) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_LOCK;
                    end
                end else begin
                    state_nxt_s = ST_LOCK;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM, lock, round-robin pointer and orphan flag registers
    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            state_r      <= ST_IDLE;
            lock_vc_r    <= {VW{1'b0}};
            rr_ptr_r     <= {VW{1'b0}};
            err_orphan_r <= 1'b0;
            err_vc_r     <= {VW{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            lock_vc_r    <= lock_vc_nxt_s;
            rr_ptr_r     <= rr_ptr_nxt_s;
            err_orphan_r <= orphan_s;
            if (orphan_s) begin
                err_vc_r <= win_s;
            end
        end
    end

    // Output decode from registered lock state and FIFO contents only
    always_comb begin
        out_valid = {NUM_VC{1'b0}};
        out_flit  = {FLIT_W{1'b0}};
        if ((state_r == ST_LOCK) && !empty_s[lock_vc_r]) begin
            out_valid[lock_vc_r] = 1'b1;
            out_flit             = head_s[lock_vc_r];
        end else begin
            out_valid = {NUM_VC{1'b0}};
            out_flit  = {FLIT_W{1'b0}};
        end
    end

    assign err_orphan = err_orphan_r;
    assign err_vc     = err_vc_r;

`ifdef NOC_INJ_STATS_EN
    logic        tail_xfer_s;
    logic [31:0] stat_pkts_r;
    logic [15:0] stat_orphans_r;

    assign tail_xfer_s = (state_r == ST_LOCK) & pop_s[lock_vc_r] & head_s[lock_vc_r][FLIT_W-2];

    // Saturating packet and orphan counters
    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            stat_pkts_r    <= 32'd0;
            stat_orphans_r <= 16'd0;
        end else begin
            if (tail_xfer_s && (stat_pkts_r != 32'hFFFF_FFFF)) begin
                stat_pkts_r <= stat_pkts_r + 32'd1;
            end
            if (orphan_s && (stat_orphans_r != 16'hFFFF)) begin
                stat_orphans_r <= stat_orphans_r + 16'd1;
            end
        end
    end

    assign stat_pkts    = stat_pkts_r;
    assign stat_orphans = stat_orphans_r;
`endif

endmodule

// File: tb/tb_noc_inject_buffer.sv
// ---------------------------------------------------------------------------
// tb_noc_inject_buffer
//
// Bench for noc_inject_buffer. Each accepted input flit is classified by a
// per-VC packet-framing model (expected on the output, or an orphan) and
// queued; a monitor pops and compares whenever a flit transfers or an orphan
// is flagged. Directed sequences check latency, arbitration order, back-
// pressure, orphan handling, single-flit packets and mid-packet reset;
// a random phase then exercises everything together.
// ---------------------------------------------------------------------------
module tb_noc_inject_buffer;

    localparam int NV = 4;
    localparam int DP = 4;
    localparam int FW = 10;

    logic                    noc_clk = 1'b0;
    logic                    noc_rst_n = 1'b0;
    logic [NV-1:0]           in_valid = '0;
    logic [NV-1:0][FW-1:0]   in_flit = '0;
    logic [NV-1:0]           in_ready;
    logic [NV-1:0]           out_valid;
    logic [FW-1:0]           out_flit;
    logic [NV-1:0]           out_ready = '1;
    logic                    err_orphan;
    logic [1:0]              err_vc;
`ifdef NOC_INJ_STATS_EN
    logic [31:0]             stat_pkts;
    logic [15:0]             stat_orphans;
`endif

    noc_inject_buffer #(.NUM_VC(NV), .DEPTH(DP), .FLIT_W(FW)) dut (
        .noc_clk      (noc_clk),
        .noc_rst_n    (noc_rst_n),
        .in_valid     (in_valid),
        .in_flit      (in_flit),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_flit     (out_flit),
        .out_ready    (out_ready),
        .err_orphan   (err_orphan),
`ifdef NOC_INJ_STATS_EN
        .stat_pkts    (stat_pkts),
        .stat_orphans (stat_orphans),
`endif
        .err_vc       (err_vc)
    );

    always #5 noc_clk = ~noc_clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    // Reference model: per-VC expected output flits and pending orphans
    logic [FW-1:0] exp_q [NV][$];
    int            orph_cnt [NV];
    bit            in_pkt_m [NV];
    int            lock_m = -1;

    // Per-cycle history of observed outputs, indexed by cycle number
    logic [NV-1:0] ov_hist [1024];
    bit            xf_hist [1024];
    bit            eo_hist [1024];
    logic [1:0]    ev_hist [1024];

    always @(posedge noc_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, wanted %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [FW-1:0] mk(input bit h, input bit t, input logic [7:0] p);
        return {h, t, p};
    endfunction

    function automatic int pending();
        int s;
        s = 0;
        for (int v = 0; v < NV; v++) s += exp_q[v].size() + orph_cnt[v];
        return s;
    endfunction

    // Monitor: classify accepted inputs, then score outputs and orphan flags
    initial begin
        int h;
        int w;
        logic [FW-1:0] f;
        logic [FW-1:0] e;
        for (int v = 0; v < NV; v++) begin
            orph_cnt[v] = 0;
            in_pkt_m[v] = 1'b0;
        end
        forever begin
            @(negedge noc_clk);
            if (noc_rst_n) begin
                h = cyc % 1024;
                ov_hist[h] = out_valid;
                xf_hist[h] = |(out_valid & out_ready);
                eo_hist[h] = err_orphan;
                ev_hist[h] = err_vc;
                for (int v = 0; v < NV; v++) begin
                    if (in_valid[v] && in_ready[v]) begin
                        f = in_flit[v];
                        if (in_pkt_m[v]) begin
                            exp_q[v].push_back(f);
                            if (f[FW-2]) in_pkt_m[v] = 1'b0;
                        end else if (f[FW-1]) begin
                            exp_q[v].push_back(f);
                            in_pkt_m[v] = !f[FW-2];
                        end else begin
                            orph_cnt[v]++;
                        end
                    end
                end
                check("out_valid_onehot", 64'($onehot0(out_valid)), 64'd1);
                if (out_valid == '0) begin
                    check("idle_flit_zero", out_flit, 0);
                end else begin
                    w = 0;
                    for (int v = NV - 1; v >= 0; v--) if (out_valid[v]) w = v;
                    if (lock_m >= 0) check("no_interleave", w, lock_m);
                    if (out_ready[w]) begin
                        check("sb_has_flit", 64'(exp_q[w].size() > 0), 64'd1);
                        if (exp_q[w].size() > 0) begin
                            e = exp_q[w].pop_front();
                            check("out_flit", out_flit, e);
                            if (lock_m < 0) begin
                                if (!e[FW-2]) lock_m = w;
                            end else if (e[FW-2]) begin
                                lock_m = -1;
                            end
                        end
                    end
                end
                if (err_orphan) begin
                    check("orphan_expected", 64'(orph_cnt[err_vc] > 0), 64'd1);
                    if (orph_cnt[err_vc] > 0) orph_cnt[err_vc]--;
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge noc_clk);
        #1;
    endtask

    task automatic drive(input int v, input logic [FW-1:0] f);
        in_valid[v] = 1'b1;
        in_flit[v]  = f;
    endtask

    task automatic clear_in();
        in_valid = '0;
    endtask

    task automatic do_reset();
        noc_rst_n = 1'b0;
        in_valid  = '0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_flit", out_flit, 0);
        check("rst_in_ready", in_ready, 4'hF);
        check("rst_err_orphan", err_orphan, 0);
        check("rst_err_vc", err_vc, 0);
        for (int v = 0; v < NV; v++) begin
            exp_q[v].delete();
            orph_cnt[v] = 0;
            in_pkt_m[v] = 1'b0;
        end
        lock_m    = -1;
        out_ready = 4'hF;
        repeat (2) @(posedge noc_clk);
        #1 noc_rst_n = 1'b1;
        check("rst_rr_ptr", dut.rr_ptr_r, 0);
`ifdef NOC_INJ_STATS_EN
        check("rst_stat_pkts", stat_pkts, 0);
        check("rst_stat_orphans", stat_orphans, 0);
`endif
    endtask

    initial begin
        int t0;
        int k;
        #1;
        do_reset();

        // 3-flit packet on VC0: offered cycles 2..4, idle again in cycle 5
        next_cycle(); t0 = cyc; drive(0, mk(1, 0, 8'h11));
        next_cycle(); drive(0, mk(0, 0, 8'h22));
        next_cycle(); drive(0, mk(0, 1, 8'h33));
        next_cycle(); clear_in();
        repeat (4) next_cycle();
        for (int c = 2; c <= 4; c++) check("pkt3_valid", ov_hist[(t0 + c) % 1024], 4'b0001);
        check("pkt3_idle", ov_hist[(t0 + 5) % 1024], 4'b0000);

        // Headers on VC1 and VC2 together with rr_ptr 0: VC1 first, bubble, VC2
        do_reset();
        next_cycle(); t0 = cyc; drive(1, mk(1, 0, 8'hA1)); drive(2, mk(1, 0, 8'hB1));
        next_cycle(); drive(1, mk(0, 1, 8'hA2)); drive(2, mk(0, 1, 8'hB2));
        next_cycle(); clear_in();
        check("rr_after_lock1", dut.rr_ptr_r, 2);
        repeat (3) next_cycle();
        check("rr_after_lock2", dut.rr_ptr_r, 3);
        repeat (3) next_cycle();
        check("rr_vc1_c2", ov_hist[(t0 + 2) % 1024], 4'b0010);
        check("rr_vc1_c3", ov_hist[(t0 + 3) % 1024], 4'b0010);
        check("rr_bubble", ov_hist[(t0 + 4) % 1024], 4'b0000);
        check("rr_vc2_c5", ov_hist[(t0 + 5) % 1024], 4'b0100);
        check("rr_vc2_c6", ov_hist[(t0 + 6) % 1024], 4'b0100);
        check("rr_idle", ov_hist[(t0 + 7) % 1024], 4'b0000);

        // Fill VC3 under back-pressure; 5th push refused; then 1 flit/cycle
        do_reset();
        out_ready = 4'b0111;
        next_cycle(); t0 = cyc; drive(3, mk(1, 0, 8'h51));
        next_cycle(); drive(3, mk(0, 0, 8'h52));
        next_cycle(); drive(3, mk(0, 0, 8'h53));
        next_cycle(); drive(3, mk(0, 0, 8'h54));
        next_cycle(); clear_in();
        check("full_in_ready", in_ready, 4'b0111);
        drive(3, mk(0, 1, 8'h5F));
        next_cycle(); clear_in();
        check("full_still", in_ready, 4'b0111);
        out_ready = 4'hF;
        next_cycle();
        check("ready_after_pop", in_ready, 4'hF);
        repeat (2) next_cycle();
        next_cycle(); drive(3, mk(0, 1, 8'h66));
        next_cycle(); clear_in();
        repeat (3) next_cycle();
        for (int c = 2; c <= 4; c++) check("stall_offer", ov_hist[(t0 + c) % 1024], 4'b1000);
        for (int c = 5; c <= 8; c++) check("stream_xfer", 64'(xf_hist[(t0 + c) % 1024]), 64'd1);

        // Orphan data flit into empty VC2
        do_reset();
        next_cycle(); t0 = cyc; drive(2, mk(0, 0, 8'h77));
        next_cycle(); clear_in();
        repeat (4) next_cycle();
        check("orph_pre", 64'(eo_hist[(t0 + 1) % 1024]), 64'd0);
        check("orph_pulse", 64'(eo_hist[(t0 + 2) % 1024]), 64'd1);
        check("orph_vc", ev_hist[(t0 + 2) % 1024], 2);
        check("orph_post", 64'(eo_hist[(t0 + 3) % 1024]), 64'd0);
        check("orph_vc_hold", err_vc, 2);
        for (int c = 1; c <= 4; c++) check("orph_no_out", ov_hist[(t0 + c) % 1024], 4'b0000);
`ifdef NOC_INJ_STATS_EN
        check("stat_orphans", stat_orphans, 1);
`endif

        // Single-flit packet then a 2-flit packet on VC0
        do_reset();
        next_cycle(); t0 = cyc; drive(0, mk(1, 1, 8'h81));
        next_cycle(); drive(0, mk(1, 0, 8'h82));
        next_cycle(); drive(0, mk(0, 1, 8'h83));
        next_cycle(); clear_in();
        repeat (5) next_cycle();
        check("sf_single", ov_hist[(t0 + 2) % 1024], 4'b0001);
        check("sf_bubble", ov_hist[(t0 + 3) % 1024], 4'b0000);
        check("sf_hdr", ov_hist[(t0 + 4) % 1024], 4'b0001);
        check("sf_tail", ov_hist[(t0 + 5) % 1024], 4'b0001);
        check("sf_idle", ov_hist[(t0 + 6) % 1024], 4'b0000);
`ifdef NOC_INJ_STATS_EN
        check("stat_pkts", stat_pkts, 2);
`endif

        // Reset after the 2nd flit of a 4-flit packet; nothing more emitted
        do_reset();
        next_cycle(); drive(0, mk(1, 0, 8'hC1));
        next_cycle(); drive(0, mk(0, 0, 8'hC2));
        next_cycle(); drive(0, mk(0, 0, 8'hC3));
        next_cycle(); drive(0, mk(0, 1, 8'hC4));
        next_cycle(); clear_in();
        do_reset();
        next_cycle(); t0 = cyc;
        repeat (10) next_cycle();
        for (int c = 0; c < 9; c++) check("post_rst_silent", ov_hist[(t0 + c) % 1024], 4'b0000);
        check("post_rst_ready", in_ready, 4'hF);

        // Random traffic, random back-pressure
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            next_cycle();
            for (int v = 0; v < NV; v++) begin
                in_valid[v] = ($urandom_range(0, 99) < 40);
                in_flit[v]  = mk($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 4, 8'($urandom));
            end
            out_ready = 4'($urandom);
        end
        next_cycle(); clear_in(); out_ready = 4'hF;

        // Close any open packet with a tail on every VC, then drain
        for (int v = 0; v < NV; v++) begin
            k = 0;
            while (!in_ready[v] && k < 300) begin
                next_cycle();
                k++;
            end
            check("drain_push_timeout", 64'(k < 300), 64'd1);
            drive(v, mk(0, 1, 8'hEE));
            next_cycle(); clear_in();
        end
        k = 0;
        while (pending() > 0 && k < 3000) begin
            next_cycle();
            k++;
        end
        repeat (3) next_cycle();
        check("drain_done", pending(), 0);
        check("final_idle", out_valid, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Run-length guard
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, wanted completion");
        $fatal(1, "watchdog expired");
    end

endmodule
